// File: rtl/iomem_gpio_pkg.sv
// Shared register map and address field definitions for the iomem GPIO peripheral.
package iomem_gpio_pkg;

  localparam int ADDR_LSB = 2;
  localparam int ADDR_MSB = 4;

  localparam logic [2:0] REG_OUT  = 3'd0;
  localparam logic [2:0] REG_OE   = 3'd1;
  localparam logic [2:0] REG_IN   = 3'd2;
  localparam logic [2:0] REG_EN   = 3'd3;
  localparam logic [2:0] REG_RISE = 3'd4;
  localparam logic [2:0] REG_PEND = 3'd5;

endpackage

// File: rtl/gpio_sync_edge.sv
// One pin: SYNC_STAGES-deep synchroniser plus previous-value flop; edge events are
// combinational from the flops and qualified by the pin's RISE select.
module gpio_sync_edge
  import iomem_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_in,
  input  logic rise_sel,
  output logic sync_val,
  output logic rise_evt,
  output logic fall_evt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign rise_evt = sync_val & ~prev_q & rise_sel;
  assign fall_evt = ~sync_val & prev_q & ~rise_sel;

endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the PicoSoC iomem bus: OUT/OE/IN/EN/RISE/PEND registers, edge irq.
// One-cycle ready pulse per accepted access; a held valid is re-accepted only after ready drops.
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter int                   NUM_PINS    = 8,
  parameter logic [7:0]           BASE_ADDR   = 8'h03,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [NUM_PINS-1:0]  RESET_OUT   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);

  localparam logic [2:0] PRIME_CNT = 3'(SYNC_STAGES + 1);

  typedef logic [NUM_PINS-1:0] pins_t;

  pins_t       out_q, out_d;
  pins_t       oe_q, oe_d;
  pins_t       en_q, en_d;
  pins_t       rise_q, rise_d;
  pins_t       pend_q, pend_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  prime_q, prime_d;

  pins_t       sync_val, rise_evt, fall_evt;
  pins_t       wmask, wbits;
  logic        sel, wr, primed;
  logic [2:0]  offset;
  logic [31:0] rd_val;
  logic        unused_bits;

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk      (clk),
      .reset    (reset),
      .pin_in   (gpio_in[i]),
      .rise_sel (rise_q[i]),
      .sync_val (sync_val[i]),
      .rise_evt (rise_evt[i]),
      .fall_evt (fall_evt[i])
    );
  end

  assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, iomem_wstrb};

  // Bit i of a register belongs to byte lane i/8.
  always_comb begin
    offset = iomem_addr[ADDR_MSB:ADDR_LSB];
    sel    = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
    wr     = sel && (iomem_wstrb != 4'b0000);
    wbits  = iomem_wdata[NUM_PINS-1:0];
    wmask  = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      wmask[i] = iomem_wstrb[i >> 3];
    end
  end

  always_comb begin
    rd_val = '0;
    case (offset)
      REG_OUT:  rd_val[NUM_PINS-1:0] = out_q;
      REG_OE:   rd_val[NUM_PINS-1:0] = oe_q;
      REG_IN:   rd_val[NUM_PINS-1:0] = sync_val;
      REG_EN:   rd_val[NUM_PINS-1:0] = en_q;
      REG_RISE: rd_val[NUM_PINS-1:0] = rise_q;
      REG_PEND: rd_val[NUM_PINS-1:0] = pend_q;
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    oe_d   = oe_q;
    en_d   = en_q;
    rise_d = rise_q;
    pend_d = pend_q;
    if (wr) begin
      case (offset)
        REG_OUT:  out_d  = (out_q  & ~wmask) | (wbits & wmask);
        REG_OE:   oe_d   = (oe_q   & ~wmask) | (wbits & wmask);
        REG_EN:   en_d   = (en_q   & ~wmask) | (wbits & wmask);
        REG_RISE: rise_d = (rise_q & ~wmask) | (wbits & wmask);
        REG_PEND: pend_d = pend_q & ~(wbits & wmask);
        default:  ;
      endcase
    end
    // Set is applied after the clear so a same-cycle event wins over W1C.
    primed = (prime_q == PRIME_CNT);
    if (primed) begin
      pend_d = pend_d | rise_evt | fall_evt;
    end
    prime_d = primed ? prime_q : prime_q + 3'd1;
    ready_d = sel;
    rdata_d = sel ? rd_val : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= RESET_OUT;
      oe_q    <= '0;
      en_q    <= '0;
      rise_q  <= '0;
      pend_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      prime_q <= '0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      en_q    <= en_d;
      rise_q  <= rise_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      prime_q <= prime_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = oe_q;
  assign irq         = |(pend_q & en_q);

endmodule
